// File: rtl/trackball_quad_gen.sv
// ============================================================================
// Module   : trackball_quad_gen
// Purpose  : Turns signed per-report X/Y movement into paced 2-phase
//            quadrature trains, one edge per axis per step tick.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trackball_quad_gen #(
  parameter int STEP_DIV = 64,
  parameter int ACC_W    = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mv_stb,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic [1:0] scale,
  input  logic       clr,
  output logic       xa,
  output logic       xb,
  output logic       ya,
  output logic       yb,
  output logic       busy
);

  localparam int TMR_W = $clog2(STEP_DIV);
  localparam int SUM_W = ACC_W + 4;
  localparam logic [TMR_W-1:0]        c_TMR_LAST = TMR_W'(STEP_DIV - 1);
  localparam logic signed [SUM_W-1:0] c_POS_MAX  = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] c_NEG_MAX  = -c_POS_MAX;

  logic [TMR_W-1:0] r_tmr;
  logic             w_tick;
  logic [1:0]       w_a;
  logic [1:0]       w_b;
  logic [1:0]       w_nz_nxt;
  logic             r_busy;

  assign w_tick = (r_tmr == c_TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_tmr <= '0;
    else if (w_tick) r_tmr <= '0;
    else             r_tmr <= r_tmr + 1'b1;
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic signed [ACC_W-1:0] r_pend;
    logic [1:0]              r_p;
    logic                    r_a;
    logic                    r_b;
    logic [8:0]              w_d;
    logic signed [SUM_W-1:0] w_ds;
    logic signed [SUM_W-1:0] w_add;
    logic signed [SUM_W-1:0] w_step;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_nxt;
    logic                    w_up;
    logic                    w_dn;
    logic [1:0]              w_p_nxt;

    assign w_d  = (a == 0) ? dx : dy;
    assign w_ds = $signed({{(SUM_W-9){w_d[8]}}, w_d}) <<< scale;
    assign w_add = mv_stb ? w_ds : '0;

    // Direction comes from the stored value, so a same-cycle strobe cannot
    // influence the step it coincides with.
    assign w_up = w_tick & ~clr & ~r_pend[ACC_W-1] & (r_pend != '0);
    assign w_dn = w_tick & ~clr & r_pend[ACC_W-1];

    assign w_step = w_up ? SUM_W'(1) : (w_dn ? -SUM_W'(1) : '0);
    assign w_sum  = $signed({{4{r_pend[ACC_W-1]}}, r_pend}) - w_step + w_add;

    // Symmetric clamp keeps the most negative code out of the accumulator.
    always_comb begin
      w_nxt = w_sum[ACC_W-1:0];
      if (clr)                    w_nxt = '0;
      else if (w_sum > c_POS_MAX) w_nxt = c_POS_MAX[ACC_W-1:0];
      else if (w_sum < c_NEG_MAX) w_nxt = c_NEG_MAX[ACC_W-1:0];
    end

    assign w_p_nxt = w_up ? (r_p + 2'd1) : (w_dn ? (r_p - 2'd1) : r_p);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pend <= '0;
        r_p    <= 2'd0;
        r_a    <= 1'b0;
        r_b    <= 1'b0;
      end else begin
        r_pend <= w_nxt;
        r_p    <= w_p_nxt;
        r_a    <= w_p_nxt[1] ^ w_p_nxt[0];
        r_b    <= w_p_nxt[1];
      end
    end

    assign w_a[a]      = r_a;
    assign w_b[a]      = r_b;
    assign w_nz_nxt[a] = (w_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= 1'b0;
    else          r_busy <= |w_nz_nxt;
  end

  assign xa   = w_a[0];
  assign xb   = w_b[0];
  assign ya   = w_a[1];
  assign yb   = w_b[1];
  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_trackball_quad_gen.sv
// ============================================================================
// Module   : tb_trackball_quad_gen
// Purpose  : Self-checking bench for trackball_quad_gen against a
//            cycle-level arithmetic model of pending movement and phase.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trackball_quad_gen;

  localparam int STEP_DIV = 4;
  localparam int ACC_W    = 12;
  localparam int LIM      = (1 << (ACC_W - 1)) - 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mv_stb = 1'b0;
  logic [8:0] dx = '0;
  logic [8:0] dy = '0;
  logic [1:0] scale = '0;
  logic       clr = 1'b0;
  logic       xa, xb, ya, yb, busy;

  int checks = 0;
  int failures = 0;

  // Model state: pending counts, phase index (0..3) and tick timer.
  int m_pend [2];
  int m_p    [2];
  int m_tmr;
  logic m_busy;
  logic seq_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic seq_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  trackball_quad_gen #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .mv_stb(mv_stb), .dx(dx), .dy(dy),
    .scale(scale), .clr(clr), .xa(xa), .xb(xb), .ya(ya), .yb(yb), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] m_out();
    return {seq_a[m_p[0]], seq_b[m_p[0]], seq_a[m_p[1]], seq_b[m_p[1]], m_busy};
  endfunction

  function automatic int clampv(int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic model_reset();
    m_pend = '{0, 0};
    m_p    = '{0, 0};
    m_tmr  = 0;
    m_busy = 1'b0;
  endtask

  // One clock cycle with the given inputs; model advances by the same cycle.
  task automatic drive(input logic stb, input int vx, input int vy,
                       input int sc, input logic cl);
    int  d [2];
    int  st;
    int  np [2];
    logic tk;
    d = '{vx, vy};
    mv_stb = stb;
    dx     = 9'(vx);
    dy     = 9'(vy);
    scale  = 2'(sc);
    clr    = cl;
    tk = (m_tmr == STEP_DIV - 1);
    for (int a = 0; a < 2; a++) begin
      st = 0;
      if (!cl && tk) st = (m_pend[a] > 0) ? 1 : ((m_pend[a] < 0) ? -1 : 0);
      np[a] = cl ? 0 : clampv(m_pend[a] - st + ((stb) ? d[a] * (1 << sc) : 0));
      m_p[a] = (m_p[a] + st + 4) % 4;
    end
    m_pend = np;
    m_busy = (np[0] != 0) || (np[1] != 0);
    m_tmr  = (m_tmr + 1) % STEP_DIV;
    @(posedge clk);
    #1;
    mv_stb = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    mv_stb  = 1'b0;
    clr     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({xa, xb, ya, yb, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", {xa, xb, ya, yb, busy}, 5'b0);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seen [$];
    logic [1:0] prev;
    logic [1:0] want [3] = '{2'b10, 2'b11, 2'b01};
    apply_reset();
    prev = {xa, xb};
    for (int i = 0; i < 20; i++) begin
      if (i == 0) drive(1'b1, 3, 0, 0, 1'b0);
      else        drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL forward c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
      if ({xa, xb} != prev) seen.push_back({xa, xb});
      prev = {xa, xb};
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2]) begin
      failures++;
      $display("FAIL forward_seq got_edges=%0d exp_edges=3", seen.size());
    end
  endtask

  task automatic test_reverse();
    logic [1:0] seen [$];
    logic [1:0] prev;
    apply_reset();
    prev = {ya, yb};
    for (int i = 0; i < 16; i++) begin
      if (i == 0) drive(1'b1, 0, -2, 0, 1'b0);
      else        drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL reverse c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
      if ({ya, yb} != prev) seen.push_back({ya, yb});
      prev = {ya, yb};
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 2'b01 || seen[1] !== 2'b11 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reverse_seq got_edges=%0d busy=%b exp_edges=2 busy=0", seen.size(), busy);
    end
  endtask

  task automatic test_saturation();
    int vals [6] = '{255, 255, -256, -256, -256, 255};
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      if (i < 6) drive(1'b1, vals[i], 0, 3, 1'b0);
      else       drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL saturation c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL saturation_drain busy=%b exp=0", busy);
    end
  endtask

  task automatic test_simultaneous(input int second_dx, input int exp_edges);
    int   edges;
    logic [1:0] prev;
    apply_reset();
    while (m_tmr != STEP_DIV - 2) drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 1, 0, 0, 1'b0);
    prev  = {xa, xb};
    edges = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) drive(1'b1, second_dx, 0, 0, 1'b0);
      else        drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL simul%0d c%0d got=%b exp=%b", second_dx, i, {xa, xb, ya, yb, busy}, m_out());
      end
      if ({xa, xb} != prev) edges++;
      if (i == 0 && {xa, xb} !== 2'b10) begin
        checks++;
        failures++;
        $display("FAIL simul%0d_first_edge got=%b exp=10", second_dx, {xa, xb});
      end
      prev = {xa, xb};
    end
    checks++;
    if (edges != exp_edges || busy !== 1'b0) begin
      failures++;
      $display("FAIL simul%0d_edges got=%0d busy=%b exp=%0d busy=0", second_dx, edges, busy, exp_edges);
    end
  endtask

  task automatic test_clr();
    logic [1:0] held;
    apply_reset();
    drive(1'b1, 50, 0, 0, 1'b0);
    repeat (9) drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 5, 0, 0, 1'b1);
    held = {xa, xb};
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_busy got=%b exp=0", busy);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb} !== held || {xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL clr_hold c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 12, 0, 0, 1'b0);
    while (m_p[0] != 2) drive(1'b0, 0, 0, 0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({xa, xb, ya, yb, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=00000", {xa, xb, ya, yb, busy});
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) drive(1'b1, 1, 0, 0, 1'b0);
      else        drive(1'b0, 0, 0, 0, 1'b0);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL reset_after c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
    end
  endtask

  task automatic test_random();
    int vx, vy;
    logic stb, cl;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      stb = ($urandom_range(0, 5) == 0);
      cl  = ($urandom_range(0, 59) == 0);
      vx  = int'($urandom_range(0, 511)) - 256;
      vy  = int'($urandom_range(0, 511)) - 256;
      drive(stb, vx, vy, int'($urandom_range(0, 3)), cl);
      checks++;
      if ({xa, xb, ya, yb, busy} !== m_out()) begin
        failures++;
        $display("FAIL random c%0d got=%b exp=%b", i, {xa, xb, ya, yb, busy}, m_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_reverse();
    test_saturation();
    test_simultaneous(1, 2);
    test_simultaneous(-3, 4);
    test_clr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
